serial_mag_compare: RTL
=======================

SERIAL_MAG_COMPARE -- requirements
Module: serial_mag_compare

Interface
REQ-001 Parameter: WIDTH, default 8, number of bit-slice results per compared word (WIDTH >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin a new word comparison.
REQ-005 bit_valid  input  1  lt_in/eq_in/gt_in carry one valid bit-slice result this cycle, MSB first.
REQ-006 lt_in  input  1  upstream one-bit comparator "a<b" for the current slice.
REQ-007 eq_in  input  1  upstream one-bit comparator "a==b" for the current slice.
REQ-008 gt_in  input  1  upstream one-bit comparator "a>b" for the current slice.
REQ-009 busy  output  1  high while a word is being accumulated.
REQ-010 done  output  1  one-cycle pulse when a word result is final.
REQ-011 a_lt_b, a_eq_b, a_gt_b  output  1 each  registered word result, held until the next done.
REQ-012 err  output  1  at least one non-one-hot slice was seen in the last completed word.

Function
REQ-013 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-014 IDLE: start=1 -> RUN; bit counter cleared, internal result set to "equal", internal decided flag and internal error flag cleared.
REQ-015 IDLE: bit_valid ignored; counter and outputs unchanged.
REQ-016 RUN: each cycle with bit_valid=1 increments the counter by 1; bit_valid=0 is a stall (no state change).
REQ-017 RUN, valid slice, decided=0: gt_in only -> internal result "greater", decided=1; lt_in only -> "less", decided=1; eq_in only -> unchanged.
REQ-018 RUN, valid slice, decided=1: slice counted, internal result unchanged (first differing MSB wins).
REQ-019 RUN, valid slice not exactly one-hot (none or several set): counted, internal result unchanged, internal error flag set.
REQ-020 RUN: start ignored.
REQ-021 On the edge sampling the WIDTH-th valid slice: state -> DONE; done=1 for exactly one cycle; result outputs and err updated on that same edge (including the final slice); busy=0.
REQ-022 Result outputs always exactly one-hot after the first done; between words they hold the last result.
REQ-023 DONE lasts one cycle, then IDLE; start=1 while in DONE is accepted identically to IDLE (back-to-back words, no idle gap).
REQ-024 busy=1 exactly while in RUN.
REQ-025 Counter width ceil(log2(WIDTH+1)); it never exceeds WIDTH.

Reset
REQ-026 rst=1 forces, immediately and independent of clk: state IDLE, counter 0, busy=0, done=0, a_lt_b=0, a_eq_b=0, a_gt_b=0, err=0, internal flags cleared.
REQ-027 rst asserted mid-word discards the partial word; no done is produced for it.
REQ-028 After rst deasserts, the first start is accepted on the next rising edge.

Verification (WIDTH=4; slices listed MSB first)
REQ-029 A=1010, B=1001: slices eq,eq,gt,lt on 4 consecutive cycles -> done pulses one cycle after the 4th slice edge; a_gt_b=1, others 0; err=0.
REQ-030 A=B=0110: four eq slices -> a_eq_b=1, err=0; a second start in the DONE cycle with A=0011, B=1000 (lt,eq,gt,gt) -> next done gives a_lt_b=1.
REQ-031 Stall: four eq slices with bit_valid low for 3 cycles between each -> done only after the 4th valid slice; busy=1 throughout; prior results held until done.
REQ-032 Slice 2 driven lt_in=gt_in=1, others eq -> done with err=1, a_eq_b=1; the next clean word -> err=0.
REQ-033 rst pulse after 2 valid slices -> all outputs 0 immediately, no done; a new start with four gt-first slices -> a_gt_b=1.
REQ-034 bit_valid pulses in IDLE without start -> no busy, no done, outputs unchanged.

Source files
------------

// File: rtl/serial_mag_compare.sv
// Serial magnitude comparator: folds WIDTH MSB-first one-bit compare slices
// into a registered word result (less / equal / greater) plus an error flag
// for slices that were not exactly one-hot.
module serial_mag_compare #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_valid,
    input  logic lt_in,
    input  logic eq_in,
    input  logic gt_in,
    output logic busy,
    output logic done,
    output logic a_lt_b,
    output logic a_eq_b,
    output logic a_gt_b,
    output logic err
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        RES_EQ,
        RES_LT,
        RES_GT
    } res_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    res_t             res_reg, res_next;
    logic             decided_reg, decided_next;
    logic             serr_reg, serr_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             lt_reg, lt_next;
    logic             eq_reg, eq_next;
    logic             gt_reg, gt_next;
    logic             err_reg, err_next;
    logic             slice_onehot;

    // Exactly one of the three slice flags set: odd parity excluding all-three.
    assign slice_onehot = (lt_in ^ eq_in ^ gt_in) & ~(lt_in & eq_in & gt_in);

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign a_lt_b = lt_reg;
    assign a_eq_b = eq_reg;
    assign a_gt_b = gt_reg;
    assign err    = err_reg;

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            res_reg     <= RES_EQ;
            decided_reg <= 1'b0;
            serr_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            lt_reg      <= 1'b0;
            eq_reg      <= 1'b0;
            gt_reg      <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            res_reg     <= res_next;
            decided_reg <= decided_next;
            serr_reg    <= serr_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            lt_reg      <= lt_next;
            eq_reg      <= eq_next;
            gt_reg      <= gt_next;
            err_reg     <= err_next;
        end
    end

    // Next-state logic: accept a word, fold slices MSB first, publish on the last one.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        res_next     = res_reg;
        decided_next = decided_reg;
        serr_next    = serr_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        lt_next      = lt_reg;
        eq_next      = eq_reg;
        gt_next      = gt_reg;
        err_next     = err_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next   = RUN;
                    cnt_next     = '0;
                    res_next     = RES_EQ;
                    decided_next = 1'b0;
                    serr_next    = 1'b0;
                    busy_next    = 1'b1;
                end else begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            end

            RUN: begin
                if (bit_valid) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (!slice_onehot) begin
                        // Malformed slice: counted, but never allowed to decide.
                        serr_next = 1'b1;
                    end else if (!decided_reg) begin
                        // First differing slice from the MSB settles the word.
                        if (gt_in) begin
                            res_next     = RES_GT;
                            decided_next = 1'b1;
                        end else if (lt_in) begin
                            res_next     = RES_LT;
                            decided_next = 1'b1;
                        end
                    end

                    if (cnt_reg == LAST_IDX) begin
                        // Publish including the effect of this final slice.
                        state_next = DONE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        lt_next    = (res_next == RES_LT);
                        eq_next    = (res_next == RES_EQ);
                        gt_next    = (res_next == RES_GT);
                        err_next   = serr_next;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule
